// File: rtl/mysystem_sdramclock_seq_pkg.sv
// mysystem_sdramclock_seq_pkg: shared FSM states, register map and STATUS bit positions
package mysystem_sdramclock_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_DRV_HI  = 3'd1;
    localparam state_t ST_WAIT_HI = 3'd2;
    localparam state_t ST_DRV_LO  = 3'd3;
    localparam state_t ST_WAIT_LO = 3'd4;

    localparam logic [1:0] ADDR_CONTROL     = 2'd0;
    localparam logic [1:0] ADDR_HALF_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_PULSE_COUNT = 2'd2;
    localparam logic [1:0] ADDR_STATUS      = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_IN_LVL  = 3;

endpackage

// File: rtl/mysystem_sdramclock_seq_timer.sv
// mysystem_sdramclock_seq_timer: loadable half-period down-counter with terminal count at one
module mysystem_sdramclock_seq_timer
    import mysystem_sdramclock_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // load wins; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign tc = count == CNT_W'(1);

endmodule

// File: rtl/mysystem_sdramclock_sequencer.sv
// mysystem_sdramclock_sequencer: register-programmed SDRAM clock pulse generator writing a PIO slave
module mysystem_sdramclock_sequencer
    import mysystem_sdramclock_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctl_address,
    input  logic        ctl_chipselect,
    input  logic        ctl_write_n,
    input  logic [31:0] ctl_writedata,
    output logic [31:0] ctl_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] half_period, pulse_count, h, rem, t_count;
    logic             done, aborted, in_lvl, aborting;
    logic             wr, ctl_wr, stat_wr, start, abort, busy;
    logic             start_go, abort_go, h_one, last_lo, finish, t_tc, drv;
    logic [31:0]      status;
    logic             unused;

    assign wr       = ctl_chipselect && !ctl_write_n;
    assign ctl_wr   = wr && ctl_address == ADDR_CONTROL;
    assign stat_wr  = wr && ctl_address == ADDR_STATUS;
    assign abort    = ctl_wr && ctl_writedata[CTRL_ABORT];
    assign start    = ctl_wr && ctl_writedata[CTRL_START] && !ctl_writedata[CTRL_ABORT];
    assign busy     = state != ST_IDLE;
    assign start_go = start && !busy;
    assign abort_go = abort && busy && !aborting;
    assign h_one    = h == CNT_W'(1);
    assign last_lo  = rem == CNT_W'(1);
    assign finish   = busy && !aborting && state_nx == ST_IDLE;
    assign drv      = state == ST_DRV_HI || state == ST_DRV_LO;
    assign status   = {16'(rem), 12'b0, in_lvl, aborted, done, busy};

    assign pio_address    = 2'b00;
    assign pio_chipselect = drv;
    assign pio_write_n    = !drv;
    assign pio_writedata  = {31'b0, state == ST_DRV_HI};

    assign unused = ^{pio_readdata[31:1], ctl_writedata[31:CNT_W], t_count};

    mysystem_sdramclock_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (drv),
        .load_val (h - CNT_W'(1)),
        .count    (t_count),
        .tc       (t_tc)
    );

    // next state: an abort forces one low drive, each drive waits H-1 cycles unless H is one
    always_comb begin
        state_nx = state;
        if (abort_go)
            state_nx = ST_DRV_LO;
        else
            case (state)
                ST_IDLE:    state_nx = (start_go && pulse_count != '0) ? ST_DRV_HI : ST_IDLE;
                ST_DRV_HI:  state_nx = h_one ? ST_DRV_LO : ST_WAIT_HI;
                ST_WAIT_HI: state_nx = t_tc ? ST_DRV_LO : ST_WAIT_HI;
                ST_DRV_LO:  state_nx = (aborting || (h_one && last_lo)) ? ST_IDLE : h_one ? ST_DRV_HI : ST_WAIT_LO;
                ST_WAIT_LO: state_nx = t_tc ? ((rem == '0) ? ST_IDLE : ST_DRV_HI) : ST_WAIT_LO;
                default:    state_nx = ST_IDLE;
            endcase
    end

    // host-programmable registers, writable at any time without disturbing a running sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            half_period <= CNT_W'(1);
            pulse_count <= '0;
        end else begin
            if (wr && ctl_address == ADDR_HALF_PERIOD)
                half_period <= ctl_writedata[CNT_W-1:0];
            if (wr && ctl_address == ADDR_PULSE_COUNT)
                pulse_count <= ctl_writedata[CNT_W-1:0];
        end
    end

    // sequence state: latched half-period, remaining pulses and abort-in-progress marker
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            h        <= CNT_W'(1);
            rem      <= '0;
            aborting <= 1'b0;
        end else begin
            state    <= state_nx;
            aborting <= abort_go || (aborting && state_nx != ST_IDLE);
            if (start_go) begin
                h   <= (half_period == '0) ? CNT_W'(1) : half_period;
                rem <= pulse_count;
            end else if (abort_go)
                rem <= '0;
            else if (state == ST_DRV_LO && !aborting)
                rem <= rem - CNT_W'(1);
        end
    end

    // sticky completion flags; setting takes priority over a host clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            aborted <= 1'b0;
            in_lvl  <= 1'b0;
        end else begin
            done    <= finish || (start_go && pulse_count == '0) ||
                       (done && !start_go && !(stat_wr && ctl_writedata[STAT_DONE]));
            aborted <= (aborting && state == ST_DRV_LO) ||
                       (aborted && !start_go && !(stat_wr && ctl_writedata[STAT_ABORTED]));
            in_lvl  <= pio_readdata[0];
        end
    end

    // read data follows the address every cycle with one cycle of latency
    always_ff @(posedge clk) begin
        if (reset)
            ctl_readdata <= '0;
        else
            ctl_readdata <= (ctl_address == ADDR_HALF_PERIOD) ? 32'(half_period) :
                            (ctl_address == ADDR_PULSE_COUNT) ? 32'(pulse_count) :
                            (ctl_address == ADDR_STATUS)      ? status : 32'h0;
    end

endmodule

// File: tb/tb_mysystem_sdramclock_sequencer.sv
// tb_mysystem_sdramclock_sequencer: randomized scenario bench with an arithmetic pulse-schedule model
module tb_mysystem_sdramclock_sequencer;

    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ctl_address = 2'd1;
    logic        ctl_chipselect = 1'b0;
    logic        ctl_write_n = 1'b1;
    logic [31:0] ctl_writedata = 32'h0;
    logic [31:0] ctl_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'h0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int idle_bad = 0;
    bit mon_en = 1'b0;

    typedef struct {int c; logic [31:0] d; logic wn; logic [1:0] a;} wr_t;
    typedef struct {int c; logic [31:0] d;} ev_t;
    typedef ev_t evq_t[$];

    wr_t log_q[$];

    mysystem_sdramclock_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctl_address    (ctl_address),
        .ctl_chipselect (ctl_chipselect),
        .ctl_write_n    (ctl_write_n),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record every PIO access and count any non-idle output outside write cycles
    always @(negedge clk) begin
        if (pio_chipselect === 1'b1)
            log_q.push_back('{cyc, pio_writedata, pio_write_n, pio_address});
        else if (mon_en && (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0))
            idle_bad++;
    end

    // expected PIO writes: alternating 1/0 spaced H cycles apart starting one cycle after START
    function automatic evq_t model_writes(input int t, input int hp, input int pc, input int last);
        evq_t q;
        int h;
        h = (hp == 0) ? 1 : hp;
        for (int i = 0; i < 2 * pc; i++)
            if (t + 1 + i * h <= last)
                q.push_back('{t + 1 + i * h, 32'(~i & 1)});
        return q;
    endfunction

    task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d, output int t);
        @(negedge clk);
        ctl_chipselect = 1'b1;
        ctl_write_n = 1'b0;
        ctl_address = a;
        ctl_writedata = d;
        t = cyc;
        @(negedge clk);
        ctl_chipselect = 1'b0;
        ctl_write_n = 1'b1;
        ctl_address = 2'd3;
        ctl_writedata = $urandom;
    endtask

    task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ctl_address = a;
        @(negedge clk);
        d = ctl_readdata;
        ctl_address = 2'd3;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic [31:0] exp_r [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
        repeat (3) @(negedge clk);
        checks++;
        if (ctl_readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_readdata got=%h exp=%h", ctl_readdata, 32'h0);
        end
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0 || pio_address !== 2'b0) begin
            failures++;
            $display("FAIL reset_pio got cs=%b wn=%b wd=%h a=%0d exp cs=0 wn=1 wd=0 a=0",
                     pio_chipselect, pio_write_n, pio_writedata, pio_address);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctl_rd(2'(i), r);
            checks++;
            if (r !== exp_r[i]) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, r, exp_r[i]);
            end
        end
    endtask

    task automatic run_seq(input int hp, input int pc, input string nm);
        int t, h, d;
        logic [31:0] exp_st;
        evq_t exp;
        ctl_wr(2'd1, 32'(hp), t);
        ctl_wr(2'd2, 32'(pc), t);
        log_q.delete();
        ctl_wr(2'd0, 32'h1, t);
        h = (hp == 0) ? 1 : hp;
        d = (pc == 0) ? t + 1 : t + 1 + 2 * pc * h;
        if (pc > 0) begin
            while (cyc < d) @(negedge clk);
            exp_st = 32'h1 | ((d - 1 > t + 1 + (2 * pc - 1) * h) ? 32'h0 : 32'h10000);
            checks++;
            if (ctl_readdata !== exp_st) begin
                failures++;
                $display("FAIL %s busy_before_done hp=%0d pc=%0d got=%h exp=%h", nm, hp, pc, ctl_readdata, exp_st);
            end
        end
        while (cyc < d + 1) @(negedge clk);
        checks++;
        if (ctl_readdata !== 32'h2) begin
            failures++;
            $display("FAIL %s done_status hp=%0d pc=%0d got=%h exp=%h", nm, hp, pc, ctl_readdata, 32'h2);
        end
        exp = model_writes(t, hp, pc, d + 1);
        checks++;
        if (log_q.size() != exp.size()) begin
            failures++;
            $display("FAIL %s write_count hp=%0d pc=%0d got=%0d exp=%0d", nm, hp, pc, log_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].c !== exp[i].c || log_q[i].d !== exp[i].d || log_q[i].wn !== 1'b0 || log_q[i].a !== 2'b0) begin
                failures++;
                $display("FAIL %s write%0d got cyc=%0d data=%h wn=%b a=%0d exp cyc=%0d data=%h wn=0 a=0",
                         nm, i, log_q[i].c - t, log_q[i].d, log_q[i].wn, log_q[i].a, exp[i].c - t, exp[i].d);
            end
        end
    endtask

    task automatic test_basic;
        run_seq(3, 2, "h3_p2");
        run_seq(0, 1, "h0_p1");
    endtask

    task automatic test_zero_count;
        int t;
        logic [31:0] r;
        run_seq(5, 0, "p0");
        ctl_wr(2'd3, 32'h2, t);
        ctl_rd(2'd3, r);
        checks++;
        if (r !== 32'h0) begin
            failures++;
            $display("FAIL done_clear got=%h exp=%h", r, 32'h0);
        end
    endtask

    task automatic test_start_abort;
        int t;
        ctl_wr(2'd2, 32'd3, t);
        log_q.delete();
        ctl_wr(2'd0, 32'h3, t);
        while (cyc < t + 20) @(negedge clk);
        checks++;
        if (log_q.size() != 0 || ctl_readdata !== 32'h0) begin
            failures++;
            $display("FAIL start_abort got writes=%0d status=%h exp writes=0 status=%h", log_q.size(), ctl_readdata, 32'h0);
        end
    endtask

    task automatic test_abort;
        int t, t2;
        logic [31:0] r;
        evq_t exp;
        ctl_wr(2'd1, 32'd10, t);
        ctl_wr(2'd2, 32'd5, t);
        log_q.delete();
        ctl_wr(2'd0, 32'h1, t);
        ctl_wr(2'd1, 32'd2, t2);
        ctl_wr(2'd2, 32'd7, t2);
        ctl_wr(2'd0, 32'h1, t2);
        while (cyc < t + 11) @(negedge clk);
        ctl_wr(2'd0, 32'h2, t2);
        while (cyc < t + 15) @(negedge clk);
        checks++;
        if (ctl_readdata !== 32'h4) begin
            failures++;
            $display("FAIL abort_status got=%h exp=%h", ctl_readdata, 32'h4);
        end
        while (cyc < t + 40) @(negedge clk);
        exp = model_writes(t, 10, 5, t + 11);
        exp.push_back('{t + 13, 32'h0});
        checks++;
        if (log_q.size() != exp.size()) begin
            failures++;
            $display("FAIL abort write_count got=%0d exp=%0d", log_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].c !== exp[i].c || log_q[i].d !== exp[i].d || log_q[i].wn !== 1'b0 || log_q[i].a !== 2'b0) begin
                failures++;
                $display("FAIL abort write%0d got cyc=%0d data=%h wn=%b a=%0d exp cyc=%0d data=%h wn=0 a=0",
                         i, log_q[i].c - t, log_q[i].d, log_q[i].wn, log_q[i].a, exp[i].c - t, exp[i].d);
            end
        end
        ctl_rd(2'd1, r);
        checks++;
        if (r !== 32'd2) begin
            failures++;
            $display("FAIL busy_write_half_period got=%h exp=%h", r, 32'd2);
        end
        ctl_rd(2'd2, r);
        checks++;
        if (r !== 32'd7) begin
            failures++;
            $display("FAIL busy_write_pulse_count got=%h exp=%h", r, 32'd7);
        end
        log_q.delete();
        ctl_wr(2'd0, 32'h2, t2);
        ctl_rd(2'd3, r);
        checks++;
        if (log_q.size() != 0 || r !== 32'h4) begin
            failures++;
            $display("FAIL idle_abort got writes=%0d status=%h exp writes=0 status=%h", log_q.size(), r, 32'h4);
        end
        ctl_wr(2'd3, 32'h4, t2);
        ctl_rd(2'd3, r);
        checks++;
        if (r !== 32'h0) begin
            failures++;
            $display("FAIL aborted_clear got=%h exp=%h", r, 32'h0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++)
            run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), "random");
    endtask

    task automatic test_in_lvl;
        @(negedge clk);
        ctl_address = 2'd3;
        pio_readdata = $urandom | 32'h1;
        @(negedge clk);
        checks++;
        if (ctl_readdata[3] !== 1'b0) begin
            failures++;
            $display("FAIL in_lvl_early got=%b exp=0", ctl_readdata[3]);
        end
        @(negedge clk);
        checks++;
        if (ctl_readdata[3] !== 1'b1) begin
            failures++;
            $display("FAIL in_lvl_set got=%b exp=1", ctl_readdata[3]);
        end
        pio_readdata = $urandom & ~32'h1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ctl_readdata[3] !== 1'b0) begin
            failures++;
            $display("FAIL in_lvl_clear got=%b exp=0", ctl_readdata[3]);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        logic [31:0] r;
        logic [31:0] exp_r [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
        evq_t exp;
        ctl_wr(2'd1, 32'd4, t);
        ctl_wr(2'd2, 32'd3, t);
        log_q.delete();
        ctl_wr(2'd0, 32'h1, t);
        while (cyc < t + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        while (cyc < t + 40) @(negedge clk);
        exp = model_writes(t, 4, 3, t + 5);
        checks++;
        if (log_q.size() != exp.size()) begin
            failures++;
            $display("FAIL reset_mid write_count got=%0d exp=%0d", log_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].c !== exp[i].c || log_q[i].d !== exp[i].d) begin
                failures++;
                $display("FAIL reset_mid write%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                         i, log_q[i].c - t, log_q[i].d, exp[i].c - t, exp[i].d);
            end
        end
        for (int i = 0; i < 4; i++) begin
            ctl_rd(2'(i), r);
            checks++;
            if (r !== exp_r[i]) begin
                failures++;
                $display("FAIL reset_mid_reg%0d got=%h exp=%h", i, r, exp_r[i]);
            end
        end
    endtask

    task automatic test_idle_outputs;
        checks++;
        if (idle_bad != 0) begin
            failures++;
            $display("FAIL idle_outputs got=%0d bad cycles exp=0", idle_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_start_abort();
        test_abort();
        test_random();
        test_in_lvl();
        test_reset_mid();
        test_idle_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
